// File: rtl/cla_pkg.sv
// cla_pkg: shared slice width, sequencer state encoding and slice-count helper
package cla_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder exposing the carry into bit 3
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    assign g  = a & b;
    assign p  = a ^ b;
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s  = p ^ {c3, c2, c1, ci};
endmodule

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: WIDTH-bit add/subtract through one time-multiplexed 4-bit CLA slice, LSB nibble first
module cla_word_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NSLICE = nslice(WIDTH);
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       s;
    logic             co;
    logic             c3;
    logic             last;

    cla4_slice u_slice (
        .a  (opa_q[int'(idx_q) * SLICE_W +: SLICE_W]),
        .b  (opb_q[int'(idx_q) * SLICE_W +: SLICE_W]),
        .ci (carry_q),
        .s  (s),
        .co (co),
        .c3 (c3)
    );

    assign last = idx_q == IW'(NSLICE - 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        z_d     = z_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                opa_d   = x;
                opb_d   = sub ? ~y : y;
                carry_d = sub | cin;
                idx_d   = '0;
                z_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                z_d[int'(idx_q) * SLICE_W +: SLICE_W] = s;
                carry_d = co;
                idx_d   = last ? idx_q : idx_q + 1'b1;
                cout_d  = last ? co : cout_q;
                ovf_d   = last ? co ^ c3 : ovf_q;
                state_d = last ? DONE : RUN;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            z_q     <= z_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign z         = z_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb_cla_word_sequencer: directed self-checking bench for the 16-bit sequencer
module tb_cla_word_sequencer;
    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] z;
    logic        cout;
    logic        ovf;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    cla_word_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .res       (res),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                          output logic [15:0] rz, output logic rc, output logic ro, output int lat);
        x = a; y = b; cin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        rz = z; rc = cout; ro = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (z !== 16'h0000) begin errors++; $display("FAIL reset_z got=%h exp=0000", z); end
        checks++; if ({cout, ovf, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {cout, ovf, busy}); end
    endtask

    task automatic test_add();
        logic [15:0] rz; logic rc, ro; int lat;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, rz, rc, ro, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got=%0d exp=4", lat); end
        checks++; if (rz !== 16'h5555) begin errors++; $display("FAIL add_z got=%h exp=5555", rz); end
        checks++; if ({rc, ro} !== 2'b00) begin errors++; $display("FAIL add_cout_ovf got=%b exp=00", {rc, ro}); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL add_handoff got=%b%b exp=10", in_ready, out_valid); end
    endtask

    task automatic test_carry();
        logic [15:0] rz; logic rc, ro; int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, rz, rc, ro, lat);
        checks++; if (rz !== 16'h0000) begin errors++; $display("FAIL wrap_z got=%h exp=0000", rz); end
        checks++; if ({rc, ro} !== 2'b10) begin errors++; $display("FAIL wrap_cout_ovf got=%b exp=10", {rc, ro}); end
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rz, rc, ro, lat);
        checks++; if (rz !== 16'h8000) begin errors++; $display("FAIL sovf_z got=%h exp=8000", rz); end
        checks++; if ({rc, ro} !== 2'b01) begin errors++; $display("FAIL sovf_cout_ovf got=%b exp=01", {rc, ro}); end
    endtask

    task automatic test_sub();
        logic [15:0] rz; logic rc, ro; int lat;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, rz, rc, ro, lat);
        checks++; if (rz !== 16'hFFFE) begin errors++; $display("FAIL sub_borrow_z got=%h exp=fffe", rz); end
        checks++; if ({rc, ro} !== 2'b00) begin errors++; $display("FAIL sub_borrow_cout_ovf got=%b exp=00", {rc, ro}); end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, rz, rc, ro, lat);
        checks++; if (rz !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf_z got=%h exp=7fff", rz); end
        checks++; if ({rc, ro} !== 2'b11) begin errors++; $display("FAIL sub_ovf_cout_ovf got=%b exp=11", {rc, ro}); end
    endtask

    task automatic test_backpressure();
        int lat = -1;
        x = 16'h00A0; y = 16'h0B00; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        x = 16'h1111; y = 16'h1111; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (z !== 16'h0BA0 || {cout, ovf} !== 2'b00 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got z=%h co=%b ov=%b rdy=%b vld=%b exp z=0ba0 co=0 ov=0 rdy=0 vld=1",
                         i, z, cout, ovf, in_ready, out_valid);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got rdy=%b vld=%b busy=%b exp 1 0 0", in_ready, out_valid, busy); end
        checks++; if (z !== 16'h0BA0) begin errors++; $display("FAIL bp_ignored_req got z=%h exp=0ba0", z); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] rz; logic rc, ro; int lat;
        logic seen = 1'b0;
        x = 16'h1111; y = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        checks++;
        if (z !== 16'h0000 || {cout, ovf, busy, out_valid} !== 4'b0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset got z=%h co=%b ov=%b busy=%b vld=%b rdy=%b exp z=0000 0 0 0 0 1",
                     z, cout, ovf, busy, out_valid, in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrun_no_result got=%b exp=0", seen); end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rz, rc, ro, lat);
        checks++; if (rz !== 16'h0002 || lat !== 4) begin errors++; $display("FAIL midrun_fresh got z=%h lat=%0d exp z=0002 lat=4", rz, lat); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r0 = '0, r1 = '0;
        logic        c0 = 1'b0;
        int          t0 = -1, t1 = -1, nres = 0, nacc = 0;
        logic        acc;
        x = 16'h000F; y = 16'h0000; cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && nres < 2; cyc++) begin
            acc = in_ready & in_valid;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc == 1) begin x = 16'h0100; y = 16'h0200; cin = 1'b0; end
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (nres == 0) begin r0 = z; c0 = cout; t0 = cyc; end
                else begin r1 = z; t1 = cyc; end
                nres++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (nres !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", nres); end
        checks++; if (r0 !== 16'h0010 || c0 !== 1'b0) begin errors++; $display("FAIL b2b_first got z=%h co=%b exp z=0010 co=0", r0, c0); end
        checks++; if (r1 !== 16'h0300) begin errors++; $display("FAIL b2b_second got z=%h exp=0300", r1); end
        checks++; if (t1 - t0 !== 6) begin errors++; $display("FAIL b2b_spacing got=%0d exp=6", t1 - t0); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
